// File: rtl/button_event_ctrl_pkg.sv
// Shared state encoding and default timing constants for the button event controller.
package cycle_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FIRST_M,
        FIRST_T,
        HELD_M,
        HELD_T,
        CHORD_WAIT,
        RELEASE_WAIT
    } btn_state_t;

    localparam int DEBOUNCE_CYCLES_D   = 4;
    localparam int CHORD_WINDOW_D      = 8;
    localparam int LONG_PRESS_CYCLES_D = 64;

endpackage

// File: rtl/button_event_ctrl_if.sv
// Raw button inputs, wheel-size status and the event strobes of the button controller.
interface button_event_ctrl_if;

    logic nMode_raw;
    logic nTrip_raw;
    logic ws_active;
    logic mode_evt;
    logic trip_evt;
    logic trip_long;
    logic chord_evt;
    logic busy;

    modport master (
        output nMode_raw, nTrip_raw, ws_active,
        input  mode_evt, trip_evt, trip_long, chord_evt, busy
    );

    modport slave (
        input  nMode_raw, nTrip_raw, ws_active,
        output mode_evt, trip_evt, trip_long, chord_evt, busy
    );

endinterface

// File: rtl/button_event_ctrl_debounce.sv
// Two-flop synchroniser followed by a debounce counter; output is the accepted (debounced) level.
module button_debounce
    import cycle_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_D
) (
    input  logic clock,
    input  logic nRst,
    input  logic i_raw,
    output logic o_level
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic [CW-1:0] r_cnt;

    // The level flips on the cycle the count of disagreeing samples would reach DEBOUNCE_CYCLES.
    always_ff @(posedge clock or negedge nRst) begin
        if (!nRst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_level <= 1'b1;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            if (r_sync2 != r_level) begin
                if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                    r_level <= r_sync2;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_level = r_level;

endmodule

// File: rtl/button_event_ctrl.sv
// Classifies debounced Mode/Trip presses into short, long and chord events as one-cycle strobes.
module button_event_ctrl
    import cycle_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = DEBOUNCE_CYCLES_D,
    parameter int CHORD_WINDOW      = CHORD_WINDOW_D,
    parameter int LONG_PRESS_CYCLES = LONG_PRESS_CYCLES_D
) (
    input logic               clock,
    input logic               nRst,
    button_event_ctrl_if.slave bus
);

    localparam int WW = $clog2(CHORD_WINDOW + 1);
    localparam int HW = $clog2(LONG_PRESS_CYCLES + 1);

    logic          w_debMode;
    logic          w_debTrip;
    logic          w_pressM;
    logic          w_pressT;
    logic          w_relM;
    logic          w_relT;
    logic          w_bothUp;
    logic [HW-1:0] w_holdNext;

    btn_state_t    r_state;
    logic          r_prevMode;
    logic          r_prevTrip;
    logic [WW-1:0] r_winCnt;
    logic [HW-1:0] r_holdCnt;
    logic          r_modeEvt;
    logic          r_tripEvt;
    logic          r_tripLong;
    logic          r_chordEvt;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debMode (
        .clock   (clock),
        .nRst    (nRst),
        .i_raw   (bus.nMode_raw),
        .o_level (w_debMode)
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debTrip (
        .clock   (clock),
        .nRst    (nRst),
        .i_raw   (bus.nTrip_raw),
        .o_level (w_debTrip)
    );

    assign w_pressM   = r_prevMode & ~w_debMode;
    assign w_pressT   = r_prevTrip & ~w_debTrip;
    assign w_relM     = ~r_prevMode & w_debMode;
    assign w_relT     = ~r_prevTrip & w_debTrip;
    assign w_bothUp   = w_debMode & w_debTrip;
    // The press cycle itself is hold count 0, so trip_long lands LONG_PRESS_CYCLES after the press.
    assign w_holdNext = (r_holdCnt == HW'(LONG_PRESS_CYCLES)) ? r_holdCnt : r_holdCnt + HW'(1);

    always_ff @(posedge clock or negedge nRst) begin
        if (!nRst) begin
            r_state    <= IDLE;
            r_prevMode <= 1'b1;
            r_prevTrip <= 1'b1;
            r_winCnt   <= '0;
            r_holdCnt  <= '0;
            r_modeEvt  <= 1'b0;
            r_tripEvt  <= 1'b0;
            r_tripLong <= 1'b0;
            r_chordEvt <= 1'b0;
        end else begin
            r_prevMode <= w_debMode;
            r_prevTrip <= w_debTrip;
            r_modeEvt  <= 1'b0;
            r_tripEvt  <= 1'b0;
            r_tripLong <= 1'b0;
            r_chordEvt <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_winCnt  <= '0;
                    r_holdCnt <= '0;
                    if (w_pressM && w_pressT) begin
                        r_chordEvt <= ~bus.ws_active;
                        r_state    <= CHORD_WAIT;
                    end else if (w_pressM) begin
                        r_state <= FIRST_M;
                    end else if (w_pressT) begin
                        r_holdCnt <= HW'(1);
                        r_state   <= FIRST_T;
                    end
                end
                FIRST_M: begin
                    if (w_pressT && (r_winCnt < WW'(CHORD_WINDOW))) begin
                        r_chordEvt <= ~bus.ws_active;
                        r_state    <= CHORD_WAIT;
                    end else if (w_relM) begin
                        r_modeEvt <= 1'b1;
                        r_state   <= IDLE;
                    end else if (r_winCnt == WW'(CHORD_WINDOW)) begin
                        r_state <= HELD_M;
                    end else begin
                        r_winCnt <= r_winCnt + WW'(1);
                    end
                end
                FIRST_T: begin
                    r_holdCnt <= w_holdNext;
                    if (w_pressM && (r_winCnt < WW'(CHORD_WINDOW))) begin
                        r_chordEvt <= ~bus.ws_active;
                        r_state    <= CHORD_WAIT;
                    end else if (w_relT) begin
                        r_tripEvt <= 1'b1;
                        r_state   <= IDLE;
                    end else if (r_winCnt == WW'(CHORD_WINDOW)) begin
                        r_state <= HELD_T;
                    end else begin
                        r_winCnt <= r_winCnt + WW'(1);
                    end
                end
                HELD_M: begin
                    if (w_relM) begin
                        r_modeEvt <= 1'b1;
                        r_state   <= IDLE;
                    end else if (w_pressT) begin
                        r_state <= RELEASE_WAIT;
                    end
                end
                HELD_T: begin
                    r_holdCnt <= w_holdNext;
                    if (w_relT) begin
                        r_tripEvt <= 1'b1;
                        r_state   <= IDLE;
                    end else if (w_holdNext == HW'(LONG_PRESS_CYCLES)) begin
                        r_tripLong <= 1'b1;
                        r_state    <= RELEASE_WAIT;
                    end else if (w_pressM) begin
                        r_state <= RELEASE_WAIT;
                    end
                end
                CHORD_WAIT, RELEASE_WAIT: begin
                    if (w_bothUp) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.mode_evt  = r_modeEvt;
    assign bus.trip_evt  = r_tripEvt;
    assign bus.trip_long = r_tripLong;
    assign bus.chord_evt = r_chordEvt;
    assign bus.busy      = (r_state != IDLE) | ~w_debMode | ~w_debTrip;

endmodule

// File: tb/tb_button_event_ctrl.sv
// Directed bench for button_event_ctrl: latencies and strobe counts are hand-computed for 4/8/64.
module tb_button_event_ctrl;

    logic clock = 1'b0;
    logic nRst;

    button_event_ctrl_if bus ();

    button_event_ctrl #(
        .DEBOUNCE_CYCLES   (4),
        .CHORD_WINDOW      (8),
        .LONG_PRESS_CYCLES (64)
    ) dut (
        .clock (clock),
        .nRst  (nRst),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int total;
    int bad;
    int cyc;
    int t0;
    int nMode, nTrip, nLong, nChord, nBusy, nMulti;
    int tMode, tTrip, tLong, tChord, tBusy;

    task automatic checkOutput(input string tag, input int actual, input int expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    function automatic int strobeSum();
        return int'(bus.mode_evt) + int'(bus.trip_evt) + int'(bus.trip_long) + int'(bus.chord_evt);
    endfunction

    task automatic applyStimulus(input logic m, input logic t, input logic ws);
        bus.nMode_raw = m;
        bus.nTrip_raw = t;
        bus.ws_active = ws;
    endtask

    task automatic clearCounts();
        nMode = 0; nTrip = 0; nLong = 0; nChord = 0; nBusy = 0;
        tMode = -1; tTrip = -1; tLong = -1; tChord = -1; tBusy = -1;
    endtask

    // Each step samples at the falling edge, so cyc == k reflects state after the k-th rising edge.
    task automatic runCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            @(negedge clock);
            cyc++;
            if (bus.mode_evt)  begin nMode++;  if (tMode  < 0) tMode  = cyc; end
            if (bus.trip_evt)  begin nTrip++;  if (tTrip  < 0) tTrip  = cyc; end
            if (bus.trip_long) begin nLong++;  if (tLong  < 0) tLong  = cyc; end
            if (bus.chord_evt) begin nChord++; if (tChord < 0) tChord = cyc; end
            if (bus.busy)      begin nBusy++;  if (tBusy  < 0) tBusy  = cyc; end
            if (strobeSum() > 1) nMulti++;
        end
    endtask

    initial begin
        total = 0; bad = 0; cyc = 0; nMulti = 0;
        nRst = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b0);
        clearCounts();
        repeat (3) @(negedge clock);
        checkOutput("reset_busy", int'(bus.busy), 0);
        checkOutput("reset_strobes", strobeSum(), 0);
        nRst = 1'b1;

        clearCounts();
        runCycles(100);
        checkOutput("idle_strobes", nMode + nTrip + nLong + nChord, 0);
        checkOutput("idle_busy", nBusy, 0);

        // Mode held past the chord window, released: event 7 cycles after raw release.
        clearCounts();
        applyStimulus(1'b0, 1'b1, 1'b0);
        runCycles(20);
        t0 = cyc;
        applyStimulus(1'b1, 1'b1, 1'b0);
        runCycles(20);
        checkOutput("modeLong_count", nMode, 1);
        checkOutput("modeLong_latency", tMode - t0, 7);
        checkOutput("modeLong_other", nTrip + nLong + nChord, 0);
        checkOutput("modeLong_busyEnd", int'(bus.busy), 0);

        // Short Mode press released inside the chord window.
        clearCounts();
        t0 = cyc;
        applyStimulus(1'b0, 1'b1, 1'b0);
        runCycles(6);
        applyStimulus(1'b1, 1'b1, 1'b0);
        runCycles(20);
        checkOutput("modeShort_count", nMode, 1);
        checkOutput("modeShort_latency", tMode - t0, 13);

        clearCounts();
        applyStimulus(1'b1, 1'b0, 1'b0);
        runCycles(3);
        applyStimulus(1'b1, 1'b1, 1'b0);
        runCycles(20);
        checkOutput("glitch_strobes", nMode + nTrip + nLong + nChord, 0);
        checkOutput("glitch_busy", nBusy, 0);

        clearCounts();
        t0 = cyc;
        applyStimulus(1'b1, 1'b0, 1'b0);
        runCycles(100);
        checkOutput("tripLong_pressSeen", tBusy - t0, 6);
        checkOutput("tripLong_latency", tLong - t0, 70);
        checkOutput("tripLong_count", nLong, 1);
        applyStimulus(1'b1, 1'b1, 1'b0);
        runCycles(20);
        checkOutput("tripLong_noTripEvt", nTrip, 0);
        checkOutput("tripLong_countAfter", nLong, 1);
        checkOutput("tripLong_busyEnd", int'(bus.busy), 0);

        // Trip held past the window but released before the long threshold.
        clearCounts();
        t0 = cyc;
        applyStimulus(1'b1, 1'b0, 1'b0);
        runCycles(20);
        applyStimulus(1'b1, 1'b1, 1'b0);
        runCycles(20);
        checkOutput("tripHeld_count", nTrip, 1);
        checkOutput("tripHeld_latency", tTrip - t0, 27);
        checkOutput("tripHeld_noLong", nLong, 0);

        clearCounts();
        t0 = cyc;
        applyStimulus(1'b0, 1'b1, 1'b0);
        runCycles(5);
        applyStimulus(1'b0, 1'b0, 1'b0);
        runCycles(30);
        checkOutput("chord_count", nChord, 1);
        checkOutput("chord_latency", tChord - t0, 12);
        applyStimulus(1'b1, 1'b1, 1'b0);
        runCycles(20);
        checkOutput("chord_countAfter", nChord, 1);
        checkOutput("chord_other", nMode + nTrip + nLong, 0);
        checkOutput("chord_busyEnd", int'(bus.busy), 0);

        // Chord during wheel-size entry is silent; reset mid-hold, then buttons still held re-press.
        clearCounts();
        applyStimulus(1'b0, 1'b1, 1'b1);
        runCycles(5);
        applyStimulus(1'b0, 1'b0, 1'b1);
        runCycles(30);
        checkOutput("chordWs_strobes", nMode + nTrip + nLong + nChord, 0);
        checkOutput("chordWs_busyHeld", int'(bus.busy), 1);
        nRst = 1'b0;
        #1;
        checkOutput("midReset_busy", int'(bus.busy), 0);
        checkOutput("midReset_strobes", strobeSum(), 0);
        @(negedge clock);
        nRst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        clearCounts();
        t0 = cyc;
        runCycles(15);
        checkOutput("postReset_chordCount", nChord, 1);
        checkOutput("postReset_chordLatency", tChord - t0, 7);
        applyStimulus(1'b1, 1'b1, 1'b0);
        runCycles(20);
        checkOutput("postReset_busyEnd", int'(bus.busy), 0);

        checkOutput("strobes_onehot", nMulti, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
